// File: rtl/data_qsync_hl_send_pacer.sv
// Source-side pacer for a high-to-low quasi-synchronous synchronizer: a small FIFO drained
// by single-cycle send_s pulses spaced at least clk_ratio cycles apart, data_s held between sends.
module data_qsync_hl_send_pacer #(
    parameter int width     = 8,
    parameter int clk_ratio = 2,
    parameter int depth     = 4
) (
    input  logic                     clk_s,
    input  logic                     rst_s,
    input  logic                     init_s,
    input  logic                     push_valid,
    input  logic [width-1:0]         push_data,
    output logic                     push_ready,
    output logic                     send_s,
    output logic [width-1:0]         data_s,
    output logic [$clog2(depth):0]   level,
    output logic                     busy
);
    localparam int PTR_W = $clog2(depth);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(clk_ratio);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(depth);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(clk_ratio - 1);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             clr;
    logic             wr_en;
    logic             fire;

    assign clr        = rst_s | init_s;
    assign push_ready = (level != LEVEL_FULL);
    assign wr_en      = push_valid && push_ready;
    assign fire       = (level != '0) && (cnt == '0);
    assign busy       = (level != '0) || (cnt != '0);

    // Storage is never cleared; pointers and level alone decide which entries are live.
    always_ff @(posedge clk_s) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_s) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            send_s <= 1'b0;
            data_s <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                send_s <= 1'b1;
                data_s <= mem[rd_ptr];
                cnt    <= CNT_RELOAD;
            end else begin
                send_s <= 1'b0;
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
            case ({wr_en, fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase
        end
    end
endmodule
